// File: rtl/pcd8544_pkg.sv
// Shared constants, opcode masks and helpers for the PCD8544 display model.
package pcd8544_pkg;

   localparam int COLS      = 84;
   localparam int BANKS     = 6;
   localparam int RAM_DEPTH = COLS * BANKS;

   localparam logic [7:0] NOP_CMD    = 8'h00;
   localparam logic [7:0] FUNC_SET_M = 8'hF8;
   localparam logic [7:0] FUNC_SET_V = 8'h20;
   localparam logic [7:0] DISP_CTL_M = 8'hFA;
   localparam logic [7:0] DISP_CTL_V = 8'h08;
   localparam logic [7:0] SET_Y_M    = 8'hF8;
   localparam logic [7:0] SET_Y_V    = 8'h40;
   localparam logic [7:0] SET_X_M    = 8'h80;
   localparam logic [7:0] SET_X_V    = 8'h80;
   localparam logic [7:0] SET_TC_M   = 8'hFC;
   localparam logic [7:0] SET_TC_V   = 8'h04;
   localparam logic [7:0] SET_BIAS_M = 8'hF8;
   localparam logic [7:0] SET_BIAS_V = 8'h10;
   localparam logic [7:0] SET_VOP_M  = 8'h80;
   localparam logic [7:0] SET_VOP_V  = 8'h80;

   typedef enum logic [1:0] {
      BLANK   = 2'b00,
      ALL_ON  = 2'b01,
      NORMAL  = 2'b10,
      INVERSE = 2'b11
   } disp_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      EXEC,
      CLEAR
   } state_e;

   // y*84 + x from shifted copies of y
   function automatic logic [8:0] lin_addr(logic [2:0] y, logic [6:0] x);
      return {y, 6'b0} + {2'b0, y, 4'b0} + {4'b0, y, 2'b0} + {2'b0, x};
   endfunction

   function automatic logic op_is(logic [7:0] b, logic [7:0] m,
                                  logic [7:0] v);
      return (b & m) == v;
   endfunction

endpackage

// File: rtl/pcd8544_lcd_responder_if.sv
// PCD8544 serial pins: master drives them, the responder receives them.
interface pcd8544_lcd_responder_if;

   logic sclk;
   logic mosi;
   logic sce;
   logic dc;
   logic rst;

   modport master (output sclk, output mosi, output sce,
                   output dc, output rst);
   modport slave  (input sclk, input mosi, input sce,
                   input dc, input rst);

endinterface

// File: rtl/pcd8544_spi_rx.sv
// Synchronizes the serial pins, detects sclk rising edges and frames
// MSB-first bytes; done_o marks the edge that completes a byte.
module pcd8544_spi_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sclk_i,
   input  logic       mosi_i,
   input  logic       sce_i,
   input  logic       dc_i,
   input  logic       lcd_rst_ni,
   output logic       lcd_rst_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] byte_o,
   output logic       dc_o
);

   // bit order {rst, dc, sce, mosi, sclk}; rst starts low so the
   // LCD reset stays asserted until the pin has been seen high
   localparam logic [4:0] SYNC_RST = 5'b00100;

   logic [4:0] sync_q [SYNC_STAGES];
   logic [4:0] s;
   logic       sclk_q;
   logic       rise;
   logic [2:0] cnt_q;
   logic [6:0] sh_q;
   logic [7:0] byte_q;
   logic       dc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      end else begin
         sync_q[0] <= {lcd_rst_ni, dc_i, sce_i, mosi_i, sclk_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s         = sync_q[SYNC_STAGES-1];
   assign lcd_rst_o = ~s[4];
   assign rise      = s[0] & ~sclk_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sclk_q <= 1'b0;
      else         sclk_q <= s[0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         sh_q   <= '0;
         byte_q <= '0;
         dc_q   <= 1'b0;
      end else if (lcd_rst_o) begin
         cnt_q  <= '0;
         sh_q   <= '0;
         byte_q <= '0;
         dc_q   <= 1'b0;
      end else if (s[2]) begin
         cnt_q <= '0;
      end else if (rise) begin
         sh_q  <= {sh_q[5:0], s[1]};
         cnt_q <= cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            byte_q <= {sh_q, s[1]};
            dc_q   <= s[3];
         end
      end
   end

   assign done_o = rise & ~s[2] & (cnt_q == 3'd7) & ~lcd_rst_o;
   assign busy_o = cnt_q != 3'd0;
   assign byte_o = byte_q;
   assign dc_o   = dc_q;

endmodule

// File: rtl/pcd8544_lcd_responder.sv
// PCD8544 responder: command decode, X/Y addressing and 504-byte display RAM.
// Define LCD_RAM_CLEAR_EN to zero the RAM after every reset release.
module pcd8544_lcd_responder #(
   parameter int COLS        = pcd8544_pkg::COLS,
   parameter int BANKS       = pcd8544_pkg::BANKS,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   pcd8544_lcd_responder_if.slave spi,
   input  logic [8:0] rd_addr_i,
   output logic [7:0] rd_data_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       byte_is_data_o,
   output logic       cmd_err_o,
   output logic [6:0] x_addr_o,
   output logic [2:0] y_addr_o,
   output logic       h_mode_o,
   output logic       v_mode_o,
   output logic       pd_o,
   output logic [1:0] disp_mode_o,
   output logic [6:0] vop_o,
   output logic [2:0] bias_o,
   output logic [1:0] tc_o
);

   import pcd8544_pkg::*;

   localparam int         DEPTH = COLS * BANKS;
   localparam logic [8:0] LAST  = 9'(DEPTH - 1);
   localparam logic [6:0] X_MAX = 7'(COLS - 1);
   localparam logic [2:0] Y_MAX = 3'(BANKS - 1);
`ifdef LCD_RAM_CLEAR_EN
   localparam state_e RST_ST = CLEAR;
`else
   localparam state_e RST_ST = IDLE;
`endif

   logic       lcd_rst, rx_busy, rx_done, rx_dc;
   logic [7:0] rx_byte;

   pcd8544_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .sclk_i     (spi.sclk),
      .mosi_i     (spi.mosi),
      .sce_i      (spi.sce),
      .dc_i       (spi.dc),
      .lcd_rst_ni (spi.rst),
      .lcd_rst_o  (lcd_rst),
      .busy_o     (rx_busy),
      .done_o     (rx_done),
      .byte_o     (rx_byte),
      .dc_o       (rx_dc)
   );

   state_e     state_q, state_d;
   logic [6:0] x_q, x_d, vop_q, vop_d;
   logic [2:0] y_q, y_d, bias_q, bias_d;
   logic [1:0] tc_q, tc_d;
   logic       h_q, h_d, v_q, v_d, pd_q, pd_d;
   disp_mode_e disp_q, disp_d;
   logic       dec_err, we;
   logic [8:0] waddr;
   logic       mem_we;
   logic [8:0] mem_wa;
   logic [7:0] mem_wd;
   logic [7:0] mem_q [DEPTH];
   logic [7:0] rd_q, rd_d;
`ifdef LCD_RAM_CLEAR_EN
   logic [8:0] clr_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      state_q <= RST_ST;
      else if (lcd_rst) state_q <= RST_ST;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (rx_done) state_d = EXEC;
                else if (rx_busy) state_d = SHIFT;
         SHIFT: if (rx_done) state_d = EXEC;
                else if (!rx_busy) state_d = IDLE;
         EXEC:  state_d = rx_busy ? SHIFT : IDLE;
`ifdef LCD_RAM_CLEAR_EN
         CLEAR: if (clr_q == LAST) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_valid_o = state_q == EXEC;
      cmd_err_o    = (state_q == EXEC) && dec_err;
`ifdef LCD_RAM_CLEAR_EN
      if (state_q == CLEAR && rx_done) cmd_err_o = 1'b1;
`endif
   end

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      h_d     = h_q;
      v_d     = v_q;
      pd_d    = pd_q;
      disp_d  = disp_q;
      vop_d   = vop_q;
      bias_d  = bias_q;
      tc_d    = tc_q;
      dec_err = 1'b0;
      we      = 1'b0;
      waddr   = lin_addr(y_q, x_q);
      if (state_q == EXEC) begin
         if (rx_dc) begin
            we = 1'b1;
            if (!v_q) begin
               if (x_q == X_MAX) begin
                  x_d = '0;
                  y_d = (y_q == Y_MAX) ? '0 : y_q + 3'd1;
               end else begin
                  x_d = x_q + 7'd1;
               end
            end else begin
               if (y_q == Y_MAX) begin
                  y_d = '0;
                  x_d = (x_q == X_MAX) ? '0 : x_q + 7'd1;
               end else begin
                  y_d = y_q + 3'd1;
               end
            end
         end else if (!h_q) begin
            unique case (1'b1)
               (rx_byte == NOP_CMD): begin end
               op_is(rx_byte, FUNC_SET_M, FUNC_SET_V): begin
                  pd_d = rx_byte[2];
                  v_d  = rx_byte[1];
                  h_d  = rx_byte[0];
               end
               op_is(rx_byte, DISP_CTL_M, DISP_CTL_V):
                  disp_d = disp_mode_e'({rx_byte[2], rx_byte[0]});
               op_is(rx_byte, SET_Y_M, SET_Y_V):
                  if (rx_byte[2:0] <= Y_MAX) y_d = rx_byte[2:0];
                  else dec_err = 1'b1;
               op_is(rx_byte, SET_X_M, SET_X_V):
                  if (rx_byte[6:0] <= X_MAX) x_d = rx_byte[6:0];
                  else dec_err = 1'b1;
               default: dec_err = 1'b1;
            endcase
         end else begin
            unique case (1'b1)
               (rx_byte == NOP_CMD): begin end
               op_is(rx_byte, FUNC_SET_M, FUNC_SET_V): begin
                  pd_d = rx_byte[2];
                  v_d  = rx_byte[1];
                  h_d  = rx_byte[0];
               end
               op_is(rx_byte, SET_TC_M, SET_TC_V):     tc_d   = rx_byte[1:0];
               op_is(rx_byte, SET_BIAS_M, SET_BIAS_V): bias_d = rx_byte[2:0];
               op_is(rx_byte, SET_VOP_M, SET_VOP_V):   vop_d  = rx_byte[6:0];
               default: dec_err = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || lcd_rst) begin
         x_q    <= '0;
         y_q    <= '0;
         h_q    <= 1'b0;
         v_q    <= 1'b0;
         pd_q   <= 1'b1;
         disp_q <= BLANK;
         vop_q  <= '0;
         bias_q <= '0;
         tc_q   <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         h_q    <= h_d;
         v_q    <= v_d;
         pd_q   <= pd_d;
         disp_q <= disp_d;
         vop_q  <= vop_d;
         bias_q <= bias_d;
         tc_q   <= tc_d;
      end
   end

`ifdef LCD_RAM_CLEAR_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                clr_q <= '0;
      else if (lcd_rst)           clr_q <= '0;
      else if (state_q == CLEAR)  clr_q <= clr_q + 9'd1;
   end
`endif

   always_comb begin
      mem_we = we;
      mem_wa = waddr;
      mem_wd = rx_byte;
`ifdef LCD_RAM_CLEAR_EN
      if (state_q == CLEAR) begin
         mem_we = 1'b1;
         mem_wa = clr_q;
         mem_wd = '0;
      end
`endif
   end

   // plain synchronous RAM, contents survive both resets
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   always_comb begin
      rd_d = (rd_addr_i <= LAST) ? mem_q[rd_addr_i] : 8'h00;
`ifdef LCD_RAM_CLEAR_EN
      if (state_q == CLEAR) rd_d = 8'h00;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      rd_q <= '0;
      else if (lcd_rst) rd_q <= '0;
      else              rd_q <= rd_d;
   end

   assign rd_data_o      = rd_q;
   assign byte_data_o    = rx_byte;
   assign byte_is_data_o = rx_dc;
   assign x_addr_o       = x_q;
   assign y_addr_o       = y_q;
   assign h_mode_o       = h_q;
   assign v_mode_o       = v_q;
   assign pd_o           = pd_q;
   assign disp_mode_o    = disp_q;
   assign vop_o          = vop_q;
   assign bias_o         = bias_q;
   assign tc_o           = tc_q;

endmodule

// File: tb/tb_pcd8544_lcd_responder.sv
// Bench for pcd8544_lcd_responder: directed and random SPI traffic
// checked against a behavioural display model.
module tb_pcd8544_lcd_responder;

   localparam int SYNC = 2;

   logic       clk;
   logic       rst_ni;
   logic [8:0] rd_addr;
   logic [7:0] rd_data;
   logic       byte_valid, byte_is_data, cmd_err;
   logic [7:0] byte_data;
   logic [6:0] x_addr, vop;
   logic [2:0] y_addr, bias;
   logic       h_mode, v_mode, pd;
   logic [1:0] disp_mode, tc;

   pcd8544_lcd_responder_if spi_if ();

   pcd8544_lcd_responder #(.SYNC_STAGES(SYNC)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .spi            (spi_if.slave),
      .rd_addr_i      (rd_addr),
      .rd_data_o      (rd_data),
      .byte_valid_o   (byte_valid),
      .byte_data_o    (byte_data),
      .byte_is_data_o (byte_is_data),
      .cmd_err_o      (cmd_err),
      .x_addr_o       (x_addr),
      .y_addr_o       (y_addr),
      .h_mode_o       (h_mode),
      .v_mode_o       (v_mode),
      .pd_o           (pd),
      .disp_mode_o    (disp_mode),
      .vop_o          (vop),
      .bias_o         (bias),
      .tc_o           (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int ecount = 0;
   int lat;
   logic [7:0] rd_hist [8];

   // behavioural model
   int mx, my, mh, mv, mpd, mdisp, mvop, mbias, mtc;
   int mlast, mlastdc, exp_valid, exp_err;
   logic [7:0] mram [504];
   bit mknown [504];

   always @(negedge clk) begin
      if (byte_valid) vcount++;
      if (cmd_err) ecount++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mreset();
      mx = 0; my = 0; mh = 0; mv = 0; mpd = 1; mdisp = 0;
      mvop = 0; mbias = 0; mtc = 0; mlast = 0; mlastdc = 0;
   endtask

   task automatic m_byte(input logic [7:0] b, input logic d);
      int v;
      v = int'(b);
      exp_valid++;
      mlast = v;
      mlastdc = int'(d);
      if (d) begin
         mram[my * 84 + mx] = b;
         mknown[my * 84 + mx] = 1'b1;
         if (mv == 0) begin
            mx++;
            if (mx == 84) begin mx = 0; my = (my + 1) % 6; end
         end else begin
            my++;
            if (my == 6) begin my = 0; mx = (mx + 1) % 84; end
         end
      end else if (v == 0) begin
      end else if (v / 8 == 4) begin
         mpd = (v / 4) % 2; mv = (v / 2) % 2; mh = v % 2;
      end else if (mh == 0) begin
         if (v == 8 || v == 9 || v == 12 || v == 13)
            mdisp = ((v / 4) % 2) * 2 + v % 2;
         else if (v / 8 == 8) begin
            if (v % 8 < 6) my = v % 8; else exp_err++;
         end else if (v >= 128) begin
            if (v - 128 < 84) mx = v - 128; else exp_err++;
         end else exp_err++;
      end else begin
         if (v / 4 == 1) mtc = v % 4;
         else if (v / 8 == 2) mbias = v % 8;
         else if (v >= 128) mvop = v - 128;
         else exp_err++;
      end
   endtask

   task automatic check_state();
      chk("x_addr", 32'(x_addr), mx);
      chk("y_addr", 32'(y_addr), my);
      chk("h_mode", 32'(h_mode), mh);
      chk("v_mode", 32'(v_mode), mv);
      chk("pd", 32'(pd), mpd);
      chk("disp_mode", 32'(disp_mode), mdisp);
      chk("vop", 32'(vop), mvop);
      chk("bias", 32'(bias), mbias);
      chk("tc", 32'(tc), mtc);
      chk("byte_data", 32'(byte_data), mlast);
      chk("byte_is_data", 32'(byte_is_data), mlastdc);
      chk("byte_valid_count", vcount, exp_valid);
      chk("cmd_err_count", ecount, exp_err);
   endtask

   task automatic send_bits(input logic [7:0] b, input logic d,
                            input int nbits);
      spi_if.sce = 1'b0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_if.dc = d;
         spi_if.mosi = b[i];
         clocks(4);
         spi_if.sclk = 1'b1;
         if (i == 0) begin
            lat = 0;
            for (int k = 1; k <= 6; k++) begin
               @(posedge clk);
               #1;
               rd_hist[k] = rd_data;
               if (byte_valid && lat == 0) lat = k;
            end
            @(negedge clk);
         end else begin
            clocks(4);
         end
         spi_if.sclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic d);
      send_bits(b, d, 8);
      m_byte(b, d);
      clocks(4);
      chk("byte_latency", 32'(lat >= 1 && lat <= SYNC + 2), 1);
      check_state();
   endtask

   task automatic rd_check(input logic [8:0] a, input logic [7:0] exp);
      @(negedge clk);
      rd_addr = a;
      @(posedge clk);
      #1;
      chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp));
   endtask

   task automatic clear_wait();
`ifdef LCD_RAM_CLEAR_EN
      clocks(520);
      for (int a = 0; a < 504; a++) begin
         mram[a] = 8'h00;
         mknown[a] = 1'b1;
      end
`endif
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      spi_if.sclk = 1'b0;
      spi_if.mosi = 1'b0;
      spi_if.sce  = 1'b1;
      spi_if.dc   = 1'b0;
      spi_if.rst  = 1'b1;
      rst_ni  = 1'b0;
      rd_addr = '0;
      exp_valid = 0;
      exp_err = 0;
      mreset();
      clocks(3);
      chk("reset_pd", 32'(pd), 1);
      chk("reset_x", 32'(x_addr), 0);
      chk("reset_rd_data", 32'(rd_data), 0);
      chk("reset_byte_valid", 32'(byte_valid), 0);
      chk("reset_cmd_err", 32'(cmd_err), 0);
      rst_ni = 1'b1;
      clocks(6);
      clear_wait();
      check_state();

      // command set walk
      send_byte(8'h21, 1'b0);
      send_byte(8'h90, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h0C, 1'b0);
      send_byte(8'h21, 1'b0);
      send_byte(8'h16, 1'b0);
      send_byte(8'h06, 1'b0);
      send_byte(8'h20, 1'b0);

      // addressed write and read-back
      send_byte(8'hA1, 1'b0);
      send_byte(8'h42, 1'b0);
      send_byte(8'hFE, 1'b1);
      rd_check(9'd201, 8'hFE);

      // horizontal wrap at (83,5)
      send_byte(8'hD3, 1'b0);
      send_byte(8'h45, 1'b0);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      rd_check(9'd503, 8'hAA);
      rd_check(9'd0, 8'h55);

      // vertical wrap at (83,5)
      send_byte(8'h22, 1'b0);
      send_byte(8'hD3, 1'b0);
      send_byte(8'h45, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      rd_check(9'd503, 8'h11);
      rd_check(9'd0, 8'h22);
      send_byte(8'h20, 1'b0);

      // aborted partial byte followed by a full one
      send_bits(8'hFF, 1'b0, 5);
      spi_if.sce = 1'b1;
      clocks(8);
      send_byte(8'hA5, 1'b0);

      // out-of-range X and Y
      send_byte(8'hD5, 1'b0);
      send_byte(8'h47, 1'b0);

      // read during write returns the old byte
      send_byte(8'h8A, 1'b0);
      send_byte(8'h41, 1'b0);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h8A, 1'b0);
      @(negedge clk);
      rd_addr = 9'd94;
      send_byte(8'hC3, 1'b1);
      chk("rw_same_old", 32'(rd_hist[lat + 1]), 32'h3C);
      chk("rw_same_new", 32'(rd_hist[lat + 2]), 32'hC3);

      rd_check(9'd504, 8'h00);
      rd_check(9'd511, 8'h00);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         logic       d;
         logic [7:0] b;
         d = 1'($urandom_range(0, 1));
         b = 8'($urandom);
         send_byte(b, d);
      end
      for (int a = 0; a < 504; a++)
         if (mknown[a]) rd_check(9'(a), mram[a]);

      // LCD reset pin mid-byte
      send_bits(8'hFF, 1'b0, 3);
      spi_if.rst = 1'b0;
      clocks(4);
      spi_if.rst = 1'b1;
      clocks(6);
      mreset();
      clear_wait();
      check_state();
      send_byte(8'hA7, 1'b0);
      send_byte(8'h5A, 1'b1);
      rd_check(9'd39, 8'h5A);
      rd_check(9'd201, mram[201]);

      spi_if.sce = 1'b1;
      clocks(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
